// File: rtl/truth_table_sweeper.sv
// N-input, mode-selectable reduction function unit with a registered live path
// and an FSM that sweeps all 2^N input vectors to build the full truth table.
module truth_table_sweeper #(
    parameter int N = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         mode,
    input  logic [N-1:0]       a_in,
    output logic               f_live,
    output logic               busy,
    output logic               done,
    output logic [N-1:0]       vec,
    output logic               f_cur,
    output logic [(1<<N)-1:0]  table_out,
    output logic [N:0]         ones
);

    localparam int T = 1 << N;
    localparam logic [N-1:0] VEC_LAST = N'(T - 1);
    localparam logic [N-1:0] VEC_ONE  = N'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_busy;
    logic            w_done;
    logic            w_f_sweep;
    logic            w_f_live_nxt;
    logic [2:0]      r_mode_l;
    logic [N-1:0]    r_vec;
    logic [T-1:0]    r_table;
    logic [N:0]      r_ones;
    logic            r_f_live;

    // Modes 110 and 111 fall through to NOR.
    function automatic logic f_eval(input logic [2:0] m, input logic [N-1:0] x);
        logic r;
        case (m)
            3'b001:  r = |x;
            3'b010:  r = ~&x;
            3'b011:  r = &x;
            3'b100:  r = ^x;
            3'b101:  r = ~^x;
            default: r = ~|x;
        endcase
        return r;
    endfunction

    assign w_f_sweep    = f_eval(r_mode_l, r_vec);
    assign w_f_live_nxt = f_eval(mode, a_in);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_accept    = 1'b1;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (r_vec == VEC_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                // A start in the done cycle chains straight into the next sweep.
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mode_l <= 3'b000;
            r_vec    <= '0;
            r_table  <= '0;
            r_ones   <= '0;
            r_f_live <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_f_live <= w_f_live_nxt;
            if (w_accept) begin
                r_mode_l <= mode;
                r_vec    <= '0;
                r_table  <= '0;
                r_ones   <= '0;
            end else if (r_state == S_RUN) begin
                r_table[r_vec] <= w_f_sweep;
                r_ones         <= r_ones + (N+1)'(w_f_sweep);
                if (r_vec != VEC_LAST) begin
                    r_vec <= r_vec + VEC_ONE;
                end
            end
        end
    end

    assign f_live    = r_f_live;
    assign busy      = w_busy;
    assign done      = w_done;
    assign vec       = r_vec;
    assign f_cur     = w_f_sweep;
    assign table_out = r_table;
    assign ones      = r_ones;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: N=3 main instance plus N=1 and N=5
// instances for the parameter sweep.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       start3;
    logic [2:0] mode3;
    logic [2:0] a3;
    logic       fl3, busy3, done3, fc3;
    logic [2:0] vec3;
    logic [7:0] tab3;
    logic [3:0] ones3;

    logic       start1;
    logic [2:0] mode1;
    logic [0:0] a1;
    logic       fl1, busy1, done1, fc1;
    logic [0:0] vec1;
    logic [1:0] tab1;
    logic [1:0] ones1;

    logic        start5;
    logic [2:0]  mode5;
    logic [4:0]  a5;
    logic        fl5, busy5, done5, fc5;
    logic [4:0]  vec5;
    logic [31:0] tab5;
    logic [5:0]  ones5;

    truth_table_sweeper #(.N(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .mode(mode3), .a_in(a3),
        .f_live(fl3), .busy(busy3), .done(done3), .vec(vec3), .f_cur(fc3),
        .table_out(tab3), .ones(ones3)
    );

    truth_table_sweeper #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1), .a_in(a1),
        .f_live(fl1), .busy(busy1), .done(done1), .vec(vec1), .f_cur(fc1),
        .table_out(tab1), .ones(ones1)
    );

    truth_table_sweeper #(.N(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .mode(mode5), .a_in(a5),
        .f_live(fl5), .busy(busy5), .done(done5), .vec(vec5), .f_cur(fc5),
        .table_out(tab5), .ones(ones5)
    );

    typedef struct {
        logic [31:0] tab;
        int          ones;
    } exp_t;

    exp_t sb_q[$];
    int checks   = 0;
    int failures = 0;

    // Reference model: counts ones in x, then derives each function from the count.
    function automatic logic ref_f(input logic [2:0] m, input int x, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += x[i];
        case (m)
            3'b001:  return (c > 0);
            3'b010:  return (c != n);
            3'b011:  return (c == n);
            3'b100:  return (c % 2 == 1);
            3'b101:  return (c % 2 == 0);
            default: return (c == 0);
        endcase
    endfunction

    function automatic void push_exp(input logic [2:0] m, input int n);
        exp_t e;
        logic b;
        e.tab  = '0;
        e.ones = 0;
        for (int i = 0; i < (1 << n); i++) begin
            b        = ref_f(m, i, n);
            e.tab[i] = b;
            e.ones  += int'(b);
        end
        sb_q.push_back(e);
    endfunction

    // Entered just after the edge that accepted start; checks T RUN cycles and the done cycle.
    task automatic follow_sweep3(input logic [2:0] m, input bit toggle);
        exp_t e;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if (busy3 !== 1'b1 || done3 !== 1'b0) begin
                failures++;
                $display("FAIL sweep3_busy cycle=%0d busy=%b done=%b required busy=1 done=0", c, busy3, done3);
            end
            checks++;
            if (vec3 !== 3'(c - 1)) begin
                failures++;
                $display("FAIL sweep3_vec cycle=%0d vec=%0d required=%0d", c, vec3, c - 1);
            end
            checks++;
            if (fc3 !== ref_f(m, c - 1, 3)) begin
                failures++;
                $display("FAIL sweep3_fcur cycle=%0d f_cur=%b required=%b", c, fc3, ref_f(m, c - 1, 3));
            end
            if (toggle && c == 3) begin
                start3 = 1'b1;
                mode3  = ~m;
            end
            if (toggle && c == 5) start3 = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (done3 !== 1'b1 || busy3 !== 1'b0) begin
            failures++;
            $display("FAIL sweep3_done done=%b busy=%b required done=1 busy=0", done3, busy3);
        end
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sweep3_scoreboard_empty");
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (tab3 !== e.tab[7:0]) begin
                failures++;
                $display("FAIL sweep3_table mode=%b table=%b required=%b", m, tab3, e.tab[7:0]);
            end
            checks++;
            if (ones3 !== 4'(e.ones)) begin
                failures++;
                $display("FAIL sweep3_ones mode=%b ones=%0d required=%0d", m, ones3, e.ones);
            end
        end
    endtask

    task automatic run_sweep3(input logic [2:0] m, input bit toggle);
        @(posedge clk); #1;
        start3 = 1'b1;
        mode3  = m;
        push_exp(m, 3);
        @(posedge clk); #1;
        start3 = 1'b0;
        follow_sweep3(m, toggle);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start3 = 1'b0; mode3 = 3'b000; a3 = '0;
        start1 = 1'b0; mode1 = 3'b000; a1 = '0;
        start5 = 1'b0; mode5 = 3'b000; a5 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({fl3, busy3, done3} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl f_live/busy/done=%b required=000", {fl3, busy3, done3});
        end
        checks++;
        if (vec3 !== 3'd0 || tab3 !== 8'd0 || ones3 !== 4'd0) begin
            failures++;
            $display("FAIL reset_data vec=%0d table=%b ones=%0d required 0/0/0", vec3, tab3, ones3);
        end
        checks++;
        if (fc3 !== 1'b1) begin
            failures++;
            $display("FAIL reset_fcur f_cur=%b required=1", fc3);
        end
        checks++;
        if (busy1 !== 1'b0 || busy5 !== 1'b0 || tab5 !== 32'd0 || ones5 !== 6'd0) begin
            failures++;
            $display("FAIL reset_param busy1=%b busy5=%b table5=%h ones5=%0d required 0/0/0/0", busy1, busy5, tab5, ones5);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic live_check(input logic [2:0] m, input logic [2:0] a, input logic expv);
        @(posedge clk); #1;
        mode3 = m;
        a3    = a;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (fl3 !== expv) begin
            failures++;
            $display("FAIL live mode=%b a=%b f_live=%b required=%b", m, a, fl3, expv);
        end
    endtask

    task automatic test_live;
        live_check(3'b000, 3'b000, 1'b1);
        live_check(3'b000, 3'b100, 1'b0);
        live_check(3'b101, 3'b011, 1'b1);
        for (int i = 0; i < 8; i++) live_check(3'b100, 3'(i), ref_f(3'b100, i, 3));
        live_check(3'b011, 3'b111, 1'b1);
        live_check(3'b010, 3'b111, 1'b0);
        live_check(3'b001, 3'b010, 1'b1);
    endtask

    task automatic test_back_to_back;
        @(posedge clk); #1;
        start3 = 1'b1;
        mode3  = 3'b011;
        push_exp(3'b011, 3);
        @(posedge clk); #1;
        mode3 = 3'b101;
        push_exp(3'b101, 3);
        follow_sweep3(3'b011, 1'b0);
        @(posedge clk); #1;
        start3 = 1'b0;
        follow_sweep3(3'b101, 1'b0);
    endtask

    task automatic test_rst_midrun;
        @(posedge clk); #1;
        start3 = 1'b1;
        mode3  = 3'b000;
        @(posedge clk); #1;
        start3 = 1'b0;
        for (int c = 1; c <= 4; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy3 !== 1'b0 || done3 !== 1'b0 || tab3 !== 8'd0 || ones3 !== 4'd0 || vec3 !== 3'd0) begin
            failures++;
            $display("FAIL rst_midrun busy=%b done=%b table=%b ones=%0d vec=%0d required all 0",
                     busy3, done3, tab3, ones3, vec3);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (done3 !== 1'b0 || busy3 !== 1'b0) begin
                failures++;
                $display("FAIL rst_no_done cycle=%0d done=%b busy=%b required 0/0", c, done3, busy3);
            end
        end
        run_sweep3(3'b100, 1'b0);
    endtask

    task automatic test_param;
        exp_t e;
        int   lat1 = -1;
        int   lat5 = -1;
        bit   overlap = 1'b0;
        @(posedge clk); #1;
        start1 = 1'b1; mode1 = 3'b011;
        start5 = 1'b1; mode5 = 3'b011;
        push_exp(3'b011, 1);
        push_exp(3'b011, 5);
        @(posedge clk); #1;
        start1 = 1'b0;
        start5 = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (done1 === 1'b1 && lat1 < 0) lat1 = cyc;
            if (done5 === 1'b1 && lat5 < 0) lat5 = cyc;
            if ((busy1 & done1) | (busy5 & done5)) overlap = 1'b1;
        end
        checks++;
        if (lat1 != 3) begin
            failures++;
            $display("FAIL n1_latency done_at=%0d required=3", lat1);
        end
        checks++;
        if (lat5 != 33) begin
            failures++;
            $display("FAIL n5_latency done_at=%0d required=33", lat5);
        end
        checks++;
        if (overlap) begin
            failures++;
            $display("FAIL param_busy_done_overlap seen=1 required=0");
        end
        if (sb_q.size() < 2) begin
            checks++;
            failures++;
            $display("FAIL param_scoreboard size=%0d required=2", sb_q.size());
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (tab1 !== e.tab[1:0] || ones1 !== 2'(e.ones)) begin
                failures++;
                $display("FAIL n1_result table=%b ones=%0d required table=%b ones=%0d", tab1, ones1, e.tab[1:0], e.ones);
            end
            e = sb_q.pop_front();
            checks++;
            if (tab5 !== e.tab || ones5 !== 6'(e.ones)) begin
                failures++;
                $display("FAIL n5_result table=%h ones=%0d required table=%h ones=%0d", tab5, ones5, e.tab, e.ones);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_live();
        run_sweep3(3'b000, 1'b0);
        run_sweep3(3'b010, 1'b0);
        run_sweep3(3'b100, 1'b0);
        run_sweep3(3'b111, 1'b0);
        run_sweep3(3'b001, 1'b0);
        run_sweep3(3'b010, 1'b1);
        test_back_to_back();
        test_rst_midrun();
        test_param();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
